// File: rtl/filter_seq_ctrl_if.sv
// Handshake bundle between a frame requester and the filter sequencer.
// The requester drives start/abort/stall; the sequencer drives addresses, strobes and status.
interface filter_seq_ctrl_if #(
  parameter int ADDR_BITS = 10
);
  logic                 start;
  logic                 abort;
  logic                 stall;
  logic [ADDR_BITS-1:0] src_addr;
  logic [ADDR_BITS-1:0] dst_addr;
  logic                 dst_we;
  logic                 filt_en;
  logic                 busy;
  logic                 done;
  logic [ADDR_BITS-1:0] pixel_count;

  modport master (
    output start, abort, stall,
    input  src_addr, dst_addr, dst_we, filt_en, busy, done, pixel_count
  );

  modport slave (
    input  start, abort, stall,
    output src_addr, dst_addr, dst_we, filt_en, busy, done, pixel_count
  );
endinterface

// File: rtl/filter_seq_ctrl.sv
// Frame sequencer: walks every pixel once through read -> filter -> write,
// with stall (freeze) and abort (return to idle) control.
module filter_seq_ctrl #(
  parameter int ADDR_BITS  = 10,
  parameter int NUM_PIXELS = 1024,
  parameter int FILTER_LAT = 2
) (
  input logic               clk,
  input logic               reset,
  filter_seq_ctrl_if.slave  bus
);

  localparam int WAIT_BITS = $clog2(FILTER_LAT) + 1;
  localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(FILTER_LAT - 1);
  localparam logic [ADDR_BITS-1:0] PIX_LAST  = ADDR_BITS'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    FILT,
    WRITE,
    DONE
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] index;
  logic [WAIT_BITS-1:0] wait_cnt;
  logic                 dst_we_q;
  logic                 filt_en_q;
  logic                 done_q;
  logic                 busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      wait_cnt  <= '0;
      dst_we_q  <= 1'b0;
      filt_en_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.abort && state != IDLE) begin
        state     <= IDLE;
        index     <= '0;
        wait_cnt  <= '0;
        dst_we_q  <= 1'b0;
        filt_en_q <= 1'b0;
        done_q    <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              state  <= READ;
              index  <= '0;
              busy_q <= 1'b1;
            end
          end
          READ: begin
            state     <= FILT;
            wait_cnt  <= '0;
            filt_en_q <= 1'b1;
          end
          FILT: begin
            wait_cnt <= wait_cnt + WAIT_BITS'(1);
            if (wait_cnt == WAIT_LAST) begin
              state     <= WRITE;
              filt_en_q <= 1'b0;
              dst_we_q  <= 1'b1;
            end
          end
          WRITE: begin
            dst_we_q <= 1'b0;
            if (index == PIX_LAST) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= READ;
              index <= index + ADDR_BITS'(1);
            end
          end
          DONE: begin
            state  <= IDLE;
            done_q <= 1'b0;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Strobes are registered per state but masked while stalled, so a frozen
  // cycle neither writes nor captures and a stalled DONE re-pulses on release.
  assign bus.dst_we      = dst_we_q  & ~bus.stall;
  assign bus.filt_en     = filt_en_q & ~bus.stall;
  assign bus.done        = done_q    & ~bus.stall;
  assign bus.busy        = busy_q;
  assign bus.src_addr    = index;
  assign bus.dst_addr    = index;
  assign bus.pixel_count = index;

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Directed bench for filter_seq_ctrl: a 4-pixel/latency-2 instance and a
// 1-pixel/latency-1 instance, with hand-derived cycle-by-cycle expectations.
module tb_filter_seq_ctrl;

  localparam int AB = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  filter_seq_ctrl_if #(.ADDR_BITS(AB)) a_if ();
  filter_seq_ctrl_if #(.ADDR_BITS(AB)) b_if ();

  filter_seq_ctrl #(.ADDR_BITS(AB), .NUM_PIXELS(4), .FILTER_LAT(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  filter_seq_ctrl #(.ADDR_BITS(AB), .NUM_PIXELS(1), .FILTER_LAT(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_if.start = 1'b0; a_if.abort = 1'b0; a_if.stall = 1'b0;
    b_if.start = 1'b0; b_if.abort = 1'b0; b_if.stall = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic check_a_addr(input string tag, input int exp_addr);
    check({tag, " src"}, 32'(a_if.src_addr),    32'(exp_addr));
    check({tag, " dst"}, 32'(a_if.dst_addr),    32'(exp_addr));
    check({tag, " pix"}, 32'(a_if.pixel_count), 32'(exp_addr));
  endtask

  // Plain frame; optional extra start pulse mid-frame that must be ignored.
  task automatic run_normal(input int extra);
    int exp_addr;
    string t;
    for (int c = 0; c < 20; c++) begin
      a_if.start = (c == 0) || (c == extra);
      @(negedge clk);
      t = $sformatf("norm%0d c%0d", extra, c);
      exp_addr = (c >= 13) ? 3 : (c >= 9) ? 2 : (c >= 5) ? 1 : 0;
      check({t, " busy"}, 32'(a_if.busy), 32'(c >= 1 && c <= 17));
      check({t, " we"},   32'(a_if.dst_we), 32'(c == 4 || c == 8 || c == 12 || c == 16));
      check({t, " fe"},   32'(a_if.filt_en), 32'(c inside {2, 3, 6, 7, 10, 11, 14, 15}));
      check({t, " done"}, 32'(a_if.done), 32'(c == 17));
      check_a_addr(t, exp_addr);
      next_cycle();
    end
    a_if.start = 1'b0;
  endtask

  initial begin
    int exp_addr;
    string t;

    clear_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst busy", 32'(a_if.busy), 32'd0);
    check("rst we",   32'(a_if.dst_we), 32'd0);
    check("rst fe",   32'(a_if.filt_en), 32'd0);
    check("rst done", 32'(a_if.done), 32'd0);
    check_a_addr("rst", 0);
    check("rstB busy", 32'(b_if.busy), 32'd0);
    next_cycle();

    run_normal(-1);

    // Stall over cycles 6..8 freezes pixel 1's filter phase.
    do_reset();
    for (int c = 0; c < 22; c++) begin
      a_if.start = (c == 0);
      a_if.stall = (c >= 6 && c <= 8);
      @(negedge clk);
      t = $sformatf("stall c%0d", c);
      exp_addr = (c >= 16) ? 3 : (c >= 12) ? 2 : (c >= 5) ? 1 : 0;
      check({t, " busy"}, 32'(a_if.busy), 32'(c >= 1 && c <= 20));
      check({t, " we"},   32'(a_if.dst_we), 32'(c == 4 || c == 11 || c == 15 || c == 19));
      check({t, " fe"},   32'(a_if.filt_en), 32'(c inside {2, 3, 9, 10, 13, 14, 17, 18}));
      check({t, " done"}, 32'(a_if.done), 32'(c == 20));
      check_a_addr(t, exp_addr);
      next_cycle();
    end
    a_if.stall = 1'b0;

    // Abort during pixel 1's write: write still happens, no done, restart at 10.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      a_if.start = (c == 0) || (c == 10);
      a_if.abort = (c == 8);
      @(negedge clk);
      t = $sformatf("abort c%0d", c);
      check({t, " done"}, 32'(a_if.done), 32'd0);
      if (c == 8) begin
        check({t, " we"},  32'(a_if.dst_we), 32'd1);
        check({t, " dst"}, 32'(a_if.dst_addr), 32'd1);
      end
      if (c == 9) begin
        check({t, " busy"}, 32'(a_if.busy), 32'd0);
        check({t, " we"},   32'(a_if.dst_we), 32'd0);
        check({t, " pix"},  32'(a_if.pixel_count), 32'd0);
      end
      if (c == 11) begin
        check({t, " busy"}, 32'(a_if.busy), 32'd1);
        check({t, " src"},  32'(a_if.src_addr), 32'd0);
        check({t, " fe"},   32'(a_if.filt_en), 32'd0);
      end
      if (c == 12) check({t, " fe"}, 32'(a_if.filt_en), 32'd1);
      next_cycle();
    end
    a_if.abort = 1'b0;

    // start+abort together in IDLE, and start under stall in IDLE, are both refused.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      a_if.start = (c == 0) || (c == 2);
      a_if.abort = (c == 0);
      a_if.stall = (c == 2);
      @(negedge clk);
      check($sformatf("idle_block c%0d busy", c), 32'(a_if.busy), 32'd0);
      check($sformatf("idle_block c%0d fe", c),   32'(a_if.filt_en), 32'd0);
      next_cycle();
    end
    clear_inputs();

    // Second start at cycle 3 of an active frame has no effect.
    do_reset();
    run_normal(3);

    // Synchronous reset mid-frame, then restart.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      a_if.start = (c == 0) || (c == 8);
      reset = (c == 6);
      @(negedge clk);
      t = $sformatf("midrst c%0d", c);
      if (c == 6) check({t, " fe"}, 32'(a_if.filt_en), 32'd1);
      if (c == 7) begin
        check({t, " busy"}, 32'(a_if.busy), 32'd0);
        check({t, " we"},   32'(a_if.dst_we), 32'd0);
        check({t, " fe"},   32'(a_if.filt_en), 32'd0);
        check({t, " done"}, 32'(a_if.done), 32'd0);
        check_a_addr(t, 0);
      end
      if (c == 9) begin
        check({t, " busy"}, 32'(a_if.busy), 32'd1);
        check({t, " src"},  32'(a_if.src_addr), 32'd0);
      end
      if (c == 10) check({t, " fe"}, 32'(a_if.filt_en), 32'd1);
      next_cycle();
    end
    reset = 1'b0;

    // Single-pixel frame, latency 1: READ 1, FILT 2, WRITE 3, DONE 4, IDLE 5.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      b_if.start = (c == 0);
      @(negedge clk);
      t = $sformatf("one c%0d", c);
      check({t, " busy"}, 32'(b_if.busy), 32'(c >= 1 && c <= 4));
      check({t, " fe"},   32'(b_if.filt_en), 32'(c == 2));
      check({t, " we"},   32'(b_if.dst_we), 32'(c == 3));
      check({t, " done"}, 32'(b_if.done), 32'(c == 4));
      check({t, " dst"},  32'(b_if.dst_addr), 32'd0);
      next_cycle();
    end

    // Stall while in DONE suppresses the pulse, which re-issues on release.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      b_if.start = (c == 0);
      b_if.stall = (c == 4);
      @(negedge clk);
      t = $sformatf("onestall c%0d", c);
      check({t, " busy"}, 32'(b_if.busy), 32'(c >= 1 && c <= 5));
      check({t, " done"}, 32'(b_if.done), 32'(c == 5));
      next_cycle();
    end
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
